// File: rtl/nibble_serial_adder_if.sv
// Operand/result bundle for nibble_serial_adder; the ovf wire exists only
// when SIGNED_OVF_EN is defined.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
`ifdef SIGNED_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b, c_in,
`ifdef SIGNED_OVF_EN
        input  ovf,
`endif
        input  busy, done, sum, c_out
    );

    modport slave (
        input  start, a, b, c_in,
`ifdef SIGNED_OVF_EN
        output ovf,
`endif
        output busy, done, sum, c_out
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder: one CHUNK-bit slice per clock through a registered carry.
// Optional signed-overflow flag enabled by defining SIGNED_OVF_EN.
module nibble_serial_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nibble_serial_adder_if.slave bus
);
    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;
    logic [IDX_W-1:0] idx_r;
    logic [WIDTH-1:0] sum_r;
    logic             c_out_r;
    logic             busy_r;
    logic             done_r;
`ifdef SIGNED_OVF_EN
    logic             ovf_r;
`endif

    logic [CHUNK:0]   slice_s;
    logic             last_s;

    // Single CHUNK-bit ripple adder; returns {carry_out, sum}.
    function automatic logic [CHUNK:0] ripple_add(
        input logic [CHUNK-1:0] x,
        input logic [CHUNK-1:0] y,
        input logic             ci
    );
        logic [CHUNK-1:0] s;
        logic             c;
        c = ci;
        s = '0;
        for (int j = 0; j < CHUNK; j++) begin
            s[j] = x[j] ^ y[j] ^ c;
            c    = (x[j] & y[j]) | (c & (x[j] ^ y[j]));
        end
        return {c, s};
    endfunction

    // Current slice of the latched operands plus the running carry.
    always_comb begin
        slice_s = ripple_add(a_r[int'(idx_r)*CHUNK +: CHUNK],
                             b_r[int'(idx_r)*CHUNK +: CHUNK],
                             carry_r);
        last_s  = (idx_r == IDX_W'(N - 1));
    end

    // Control FSM, operand latch and progressive result write-back.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            idx_r   <= '0;
            sum_r   <= '0;
            c_out_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
`ifdef SIGNED_OVF_EN
            ovf_r   <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_r     <= bus.a;
                        b_r     <= bus.b;
                        carry_r <= bus.c_in;
                        idx_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    sum_r[int'(idx_r)*CHUNK +: CHUNK] <= slice_s[CHUNK-1:0];
                    carry_r <= slice_s[CHUNK];
                    idx_r   <= idx_r + IDX_W'(1);
                    if (last_s) begin
                        // Top slice holds bit WIDTH-1, so its MSB is the final sign bit.
                        c_out_r <= slice_s[CHUNK];
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
`ifdef SIGNED_OVF_EN
                        ovf_r   <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                                   (slice_s[CHUNK-1] != a_r[WIDTH-1]);
`endif
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.sum   = sum_r;
    assign bus.c_out = c_out_r;
`ifdef SIGNED_OVF_EN
    assign bus.ovf   = ovf_r;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed cases plus random
// operations compared against an arithmetic reference model.
module tb_nibble_serial_adder;
    localparam int WIDTH = 8;
    localparam int CHUNK = 4;
    localparam int N     = WIDTH / CHUNK;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full operation from an idle DUT; operand inputs are scrambled during RUN.
    task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
        int          full;
        int          sres;
        int          lat;
        bit          seen;
        full = int'(av) + int'(bv) + int'(cv);
        sres = int'($signed(av)) + int'($signed(bv)) + int'(cv);
        bus.start = 1'b1; bus.a = av; bus.b = bv; bus.c_in = cv;
        tick();
        bus.start = 1'b0;
        check("busy_after_accept", 32'(bus.busy), 32'd1);
        check("done_after_accept", 32'(bus.done), 32'd0);
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat <= N + 2) begin
            bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom); bus.c_in = 1'($urandom);
            tick();
            if (bus.done) seen = 1'b1;
            else lat++;
        end
        check("done_seen", 32'(seen), 32'd1);
        check("latency", 32'(lat), 32'(N));
        check("sum", 32'(bus.sum), 32'(full % (1 << WIDTH)));
        check("c_out", 32'(bus.c_out), 32'(full >> WIDTH));
        check("busy_at_done", 32'(bus.busy), 32'd0);
`ifdef SIGNED_OVF_EN
        check("ovf", 32'(bus.ovf), 32'((sres > 127) || (sres < -128)));
`endif
        tick();
        check("done_pulse", 32'(bus.done), 32'd0);
        check("sum_hold", 32'(bus.sum), 32'(full % (1 << WIDTH)));
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.c_in = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.c_out), 32'd0);
        rst_n = 1'b1;
        tick();

        do_op(8'd100, 8'd27, 1'b0);
        do_op(8'h0F, 8'h00, 1'b1);
        do_op(8'hFF, 8'h01, 1'b0);
        do_op(8'h7F, 8'h01, 1'b0);

        // Start while busy is ignored; start in the done cycle is accepted.
        bus.start = 1'b1; bus.a = 8'd5; bus.b = 8'd6; bus.c_in = 1'b0;
        tick();
        bus.a = 8'd200; bus.b = 8'd100;
        tick();
        bus.start = 1'b0;
        tick();
        check("ign_done", 32'(bus.done), 32'd1);
        check("ign_sum", 32'(bus.sum), 32'd11);
        check("ign_cout", 32'(bus.c_out), 32'd0);
        bus.start = 1'b1; bus.a = 8'd200; bus.b = 8'd100;
        tick();
        bus.start = 1'b0;
        check("b2b_busy", 32'(bus.busy), 32'd1);
        check("b2b_done0", 32'(bus.done), 32'd0);
        tick();
        check("b2b_done1", 32'(bus.done), 32'd0);
        tick();
        check("b2b_done2", 32'(bus.done), 32'd1);
        check("b2b_sum", 32'(bus.sum), 32'h2C);
        check("b2b_cout", 32'(bus.c_out), 32'd1);
        tick();

        // Reset mid-RUN abandons the operation.
        bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55; bus.c_in = 1'b0;
        tick();
        bus.start = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_sum", 32'(bus.sum), 32'd0);
        check("mid_rst_cout", 32'(bus.c_out), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_rst_no_done", 32'(bus.done), 32'd0);
        end

        for (int i = 0; i < 20; i++) begin
            do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
